mr3_request_unit: RTL and testbench

MR3_REQUEST_UNIT -- requirements
Module: mr3_request_unit

---
 rtl/mr3_request_unit.sv | 123 ++++++++++++
 tb/tb_mr3_request_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mr3_request_unit.sv
// MR3 pedestrian request unit: synchronizes and debounces the push-button, holds
// mr3_spot between MIN_HOLD and MAX_HOLD cycles, then enforces a cooldown.
module mr3_request_unit #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned MIN_HOLD        = 8,
    parameter int unsigned MAX_HOLD        = 64,
    parameter int unsigned COOLDOWN        = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic button_raw,
    input  logic green_road1,
    output logic mr3_spot,
    output logic request_pending,
    output logic served_pulse,
    output logic timeout_pulse
);

    localparam int unsigned TOP_A   = (MAX_HOLD > DEBOUNCE_CYCLES) ? MAX_HOLD : DEBOUNCE_CYCLES;
    localparam int unsigned CNT_TOP = (TOP_A > COOLDOWN) ? TOP_A : COOLDOWN;
    localparam int unsigned CW      = (CNT_TOP > 1) ? $clog2(CNT_TOP) : 1;

    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t DEB_LAST = cnt_t'(DEBOUNCE_CYCLES - 1);
    localparam cnt_t MIN_LAST = cnt_t'(MIN_HOLD - 1);
    localparam cnt_t MAX_LAST = cnt_t'(MAX_HOLD - 1);
    localparam cnt_t CD_LAST  = cnt_t'(COOLDOWN - 1);
    localparam cnt_t CNT_SAT  = cnt_t'(CNT_TOP - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_ASSERT,
        ST_COOLDOWN
    } state_t;

    state_t     state, state_n;
    cnt_t       cnt, cnt_n;
    logic [1:0] sync_q;
    logic       btn_s;
    logic       green_seen, green_seen_n;
    logic       served_q, served_n;
    logic       timeout_q, timeout_n;
    logic       green_any;

    assign btn_s     = sync_q[1];
    assign green_any = green_seen | green_road1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q     <= '0;
            state      <= ST_IDLE;
            cnt        <= '0;
            green_seen <= 1'b0;
            served_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], button_raw};
            state      <= state_n;
            cnt        <= cnt_n;
            green_seen <= green_seen_n;
            served_q   <= served_n;
            timeout_q  <= timeout_n;
        end
    end

    // One shared counter serves debounce, hold and cooldown; it restarts on every state entry.
    always_comb begin
        state_n      = state;
        cnt_n        = (cnt == CNT_SAT) ? cnt : cnt + cnt_t'(1);
        green_seen_n = green_seen;
        served_n     = 1'b0;
        timeout_n    = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_n        = '0;
                green_seen_n = 1'b0;
                if (btn_s) state_n = ST_DEBOUNCE;
            end
            ST_DEBOUNCE: begin
                if (!btn_s) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end else if (cnt >= DEB_LAST) begin
                    state_n      = ST_ASSERT;
                    cnt_n        = '0;
                    green_seen_n = 1'b0;
                end
            end
            ST_ASSERT: begin
                green_seen_n = green_any;
                // Service wins over expiry when green arrives on the last hold cycle.
                if (green_any && cnt >= MIN_LAST) begin
                    state_n  = ST_COOLDOWN;
                    cnt_n    = '0;
                    served_n = 1'b1;
                end else if (cnt >= MAX_LAST) begin
                    state_n   = ST_COOLDOWN;
                    cnt_n     = '0;
                    timeout_n = 1'b1;
                end
            end
            ST_COOLDOWN: begin
                green_seen_n = 1'b0;
                if (cnt >= CD_LAST && !btn_s) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign mr3_spot        = (state == ST_ASSERT);
    assign request_pending = (state == ST_DEBOUNCE) || (state == ST_ASSERT);
    assign served_pulse    = served_q;
    assign timeout_pulse   = timeout_q;

endmodule

// File: tb/tb_mr3_request_unit.sv
// Self-checking bench for mr3_request_unit: directed boundary cases plus randomized
// press/green/re-press sequences checked against closed-form timing expectations.
module tb_mr3_request_unit;

    localparam int D    = 4;
    localparam int MINH = 8;
    localparam int MAXH = 64;
    localparam int CD   = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic button_raw = 1'b0;
    logic green_road1 = 1'b0;
    logic mr3_spot, request_pending, served_pulse, timeout_pulse;

    always #5 clk = ~clk;

    mr3_request_unit #(
        .DEBOUNCE_CYCLES(D),
        .MIN_HOLD(MINH),
        .MAX_HOLD(MAXH),
        .COOLDOWN(CD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .button_raw(button_raw),
        .green_road1(green_road1),
        .mr3_spot(mr3_spot),
        .request_pending(request_pending),
        .served_pulse(served_pulse),
        .timeout_pulse(timeout_pulse)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Running event log sampled mid-cycle; steps work on differences of these totals.
    int   rise_cnt = 0, last_rise = 0, last_fall = 0, spot_total = 0, pend_total = 0;
    int   served_cnt = 0, timeout_cnt = 0, last_served = 0, last_timeout = 0, both_cnt = 0;
    logic spot_d = 1'b0;

    always @(negedge clk) begin
        spot_d <= mr3_spot;
        if (mr3_spot && !spot_d) begin
            rise_cnt  <= rise_cnt + 1;
            last_rise <= cyc;
        end
        if (!mr3_spot && spot_d) last_fall <= cyc;
        if (mr3_spot) spot_total <= spot_total + 1;
        if (request_pending) pend_total <= pend_total + 1;
        if (served_pulse) begin
            served_cnt  <= served_cnt + 1;
            last_served <= cyc;
        end
        if (timeout_pulse) begin
            timeout_cnt  <= timeout_cnt + 1;
            last_timeout <= cyc;
        end
        if (served_pulse && timeout_pulse) both_cnt <= both_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int outs();
        return int'({mr3_spot, request_pending, served_pulse, timeout_pulse});
    endfunction

    // Press from IDLE for len cycles; green pulsed on hold cycle g (none if g >= MAXH).
    task automatic do_request(input int len, input int g);
        int k, r0, s0, t0, sp0, p0, dur, rise_exp;
        bit exp_req, served_exp, done;
        exp_req    = (len >= D + 1);
        served_exp = (g < MAXH);
        dur        = !served_exp ? MAXH : ((g + 1 > MINH) ? g + 1 : MINH);
        r0 = rise_cnt; s0 = served_cnt; t0 = timeout_cnt; sp0 = spot_total; p0 = pend_total;
        k = cyc;
        rise_exp = k + D + 3;
        button_raw = 1'b1;
        done = 1'b0;
        for (int i = 1; i <= 400 && !done; i++) begin
            tick();
            if (i == len) button_raw = 1'b0;
            green_road1 = exp_req && served_exp && (cyc == rise_exp + g);
            if (exp_req) done = (cyc > rise_exp) && !mr3_spot && (i >= len);
            else         done = (i >= len + 4);
        end
        green_road1 = 1'b0;
        tick();
        chk("req_bound", int'(done), 1);
        if (exp_req) begin
            chk("rise_count", rise_cnt - r0, 1);
            chk("rise_latency", last_rise - k, D + 3);
            chk("spot_cycles", spot_total - sp0, dur);
            chk("fall_cycle", last_fall, rise_exp + dur);
            chk("served_count", served_cnt - s0, served_exp ? 1 : 0);
            chk("timeout_count", timeout_cnt - t0, served_exp ? 0 : 1);
            chk("pulse_cycle", served_exp ? last_served : last_timeout, rise_exp + dur);
        end else begin
            chk("bounce_no_rise", rise_cnt - r0, 0);
            chk("bounce_pending", pend_total - p0, len);
        end
    endtask

    // Press o cycles after the last fall of mr3_spot, held len cycles.
    task automatic second_press(input int o, input int len);
        int k, r0, w;
        bit exp_req, done;
        exp_req = (o >= CD - 2) && (len >= D + 1);
        while (cyc < last_fall + o) tick();
        r0 = rise_cnt;
        k  = cyc;
        button_raw = 1'b1;
        w = ((len > D + 4) ? len : D + 4) + 1;
        for (int i = 1; i <= w; i++) begin
            tick();
            if (i == len) button_raw = 1'b0;
        end
        chk("repress_rise_count", rise_cnt - r0, exp_req ? 1 : 0);
        if (exp_req) chk("repress_latency", last_rise - k, D + 3);
        green_road1 = 1'b1;
        tick();
        green_road1 = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            tick();
            done = !mr3_spot;
        end
        chk("settle_bound", int'(done), 1);
        repeat (CD + 5) tick();
    endtask

    initial begin
        int s0, t0, p0, r0, len1, len2, g, o;
        bit done;

        #1 reset = 1'b0;
        #1 chk("reset_outs", outs(), 0);
        repeat (3) tick();
        #2 reset = 1'b1;
        repeat (5) tick();
        chk("post_reset_idle", outs(), 0);

        // Bounce: 2 high, 1 low, 3 high
        r0 = rise_cnt; p0 = pend_total;
        button_raw = 1'b1; repeat (2) tick();
        button_raw = 1'b0; tick();
        button_raw = 1'b1; repeat (3) tick();
        button_raw = 1'b0; repeat (10) tick();
        chk("bounce_rise", rise_cnt - r0, 0);
        chk("bounce_pend", pend_total - p0, 5);

        do_request(10, 20);
        second_press(CD - 3, 10);
        do_request(10, 20);
        second_press(CD - 2, 10);
        do_request(6, 2);
        repeat (CD + 5) tick();
        do_request(5, 99);
        repeat (CD + 5) tick();
        do_request(5, MAXH - 1);
        repeat (CD + 5) tick();
        do_request(D, 0);
        do_request(D + 1, 0);
        repeat (CD + 5) tick();

        // Held through ASSERT and COOLDOWN, then re-press
        do_request(120, 5);
        repeat (CD + 5) tick();
        do_request(10, 0);
        repeat (CD + 5) tick();

        // Reset in the middle of ASSERT
        button_raw = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            tick();
            done = mr3_spot;
        end
        button_raw = 1'b0;
        chk("reset_rise_bound", int'(done), 1);
        repeat (2) tick();
        s0 = served_cnt; t0 = timeout_cnt;
        #1 reset = 1'b0;
        #1 chk("reset_async_outs", outs(), 0);
        repeat (3) tick();
        #2 reset = 1'b1;
        repeat (6) tick();
        chk("reset_release_outs", outs(), 0);
        chk("reset_no_pulse", (served_cnt - s0) + (timeout_cnt - t0), 0);

        for (int it = 0; it < 25; it++) begin
            len1 = int'($urandom_range(1, 12));
            g    = int'($urandom_range(0, 70));
            do_request(len1, g);
            if (len1 >= D + 1) begin
                o    = int'($urandom_range(1, CD + 4));
                len2 = int'($urandom_range(1, 12));
                second_press(o, len2);
            end else begin
                repeat (3) tick();
            end
        end

        chk("no_dual_pulse", both_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed no_finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
